down_timer: RTL and testbench

- Loadable down-counting timer with prescaler, one-shot and auto-reload modes, and a terminal-count pulse.
- Complement to the free-running up counter used in the board bring-up labs: counts toward zero instead of away from it, and reports when it gets there.
- Sits between switch/button inputs and LED or other logic that needs a programmable delay or periodic tick on the Zybo.

---
 rtl/down_timer_pkg.sv | 14 +
 rtl/down_timer_tick_prescaler.sv | 38 +++
 rtl/down_timer.sv | 97 +++++++++
 tb/tb_down_timer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/down_timer_pkg.sv
// Shared definitions for the down_timer block: FSM state encoding and
// mode select constants.
package down_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/down_timer_tick_prescaler.sv
// Divides clk into a one-cycle tick every PRESCALE enabled cycles.
// PRESCALE=1 degenerates to tick=en with no counter register.
module tick_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  generate
    if (PRESCALE <= 1) begin : g_direct
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, rst_n, clr};
      assign tick      = en;
    end else begin : g_cnt
      localparam int unsigned CW = $clog2(PRESCALE);
      localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

      logic [CW-1:0] cnt;

      assign tick = en & (cnt == LAST);

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (clr) begin
          cnt <= '0;
        end else if (en) begin
          cnt <= tick ? '0 : cnt + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/down_timer.sv
// Loadable down-counting timer with prescaler, one-shot / auto-reload
// modes and a registered terminal-count pulse.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             tc,
  output logic             done
);

  state_t           state, state_n;
  logic [WIDTH-1:0] reload, reload_n;
  logic [WIDTH-1:0] count_n;
  logic             tc_n;
  logic             tick;

  // Any control event restarts the prescale phase; a tick coincident with
  // load/stop/start is never acted on because those branches win below.
  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_pre (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state == ST_RUN),
    .clr  (load | stop | start),
    .tick (tick)
  );

  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload;
    tc_n     = 1'b0;

    if (load) begin
      count_n  = load_val;
      reload_n = load_val;
      if (start) begin
        state_n = (load_val != '0) ? ST_RUN : ST_IDLE;
      end else begin
        unique case (state)
          ST_RUN:  state_n = (load_val != '0) ? ST_RUN : ST_IDLE;
          default: state_n = ST_IDLE;
        endcase
      end
    end else if (stop) begin
      if (state == ST_RUN) begin
        state_n = ST_IDLE;
      end
    end else if (start) begin
      if (state != ST_RUN && count != '0) begin
        state_n = ST_RUN;
      end
    end else if (state == ST_RUN && tick) begin
      if (count > WIDTH'(1)) begin
        count_n = count - 1'b1;
      end else if (count == WIDTH'(1)) begin
        tc_n = 1'b1;
        if (mode == MODE_RELOAD) begin
          count_n = reload;
        end else begin
          count_n = '0;
          state_n = ST_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      count  <= '0;
      reload <= '0;
      tc     <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      reload <= reload_n;
      tc     <= tc_n;
    end
  end

  assign running = (state == ST_RUN);
  assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_down_timer.sv
// Bench for down_timer: one PRESCALE=1 and one PRESCALE=3 instance driven
// from the same stimulus; vector table plus free-running auto-reload run.
module tb_down_timer;

  logic       clk = 1'b0;
  logic       rst_n, load, start, stop, mode;
  logic [3:0] load_val;
  logic [3:0] c1, c3;
  logic       r1, t1, d1, r3, t3, d3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  down_timer #(.WIDTH(4), .PRESCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .mode(mode),
    .count(c1), .running(r1), .tc(t1), .done(d1)
  );

  down_timer #(.WIDTH(4), .PRESCALE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .mode(mode),
    .count(c3), .running(r3), .tc(t3), .done(d3)
  );

  typedef struct {
    bit       rst;
    bit       ld;
    bit [3:0] lv;
    bit       st;
    bit       sp;
    bit       md;
    bit       p3;
    bit [3:0] ec;
    bit       er;
    bit       et;
    bit       ed;
  } vec_t;

  typedef struct {
    int       idx;
    bit       p3;
    bit [6:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];

  function automatic void add(bit rst, bit ld, bit [3:0] lv, bit st, bit sp,
                              bit md, bit p3, bit [3:0] ec, bit er, bit et,
                              bit ed);
    vec_t v;
    v.rst = rst; v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.md = md;
    v.p3 = p3; v.ec = ec; v.er = er; v.et = et; v.ed = ed;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(bit rst, bit ld, bit [3:0] lv, bit st, bit sp, bit md);
    @(negedge clk);
    rst_n    = ~rst;
    load     = ld;
    load_val = lv;
    start    = st;
    stop     = sp;
    mode     = md;
  endtask

  initial begin
    sb_t         e;
    logic [6:0]  act;
    int          first_tc3, n_tc1, n_tc3, zero_seen;

    rst_n = 1'b0; load = 1'b0; load_val = '0; start = 1'b0; stop = 1'b0; mode = 1'b0;
    repeat (2) @(posedge clk);

    //  rst ld lv st sp md p3 | count run tc done
    add(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);   // reset state
    // one-shot from 3
    add(0, 1, 3, 0, 0, 0, 0,  3, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0,  3, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  2, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1);   // start from DONE ignored
    add(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
    // auto-reload from 2
    add(0, 1, 2, 0, 0, 1, 0,  2, 0, 0, 0);
    add(0, 0, 0, 1, 0, 1, 0,  2, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0,  1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0,  2, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0,  1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0,  2, 1, 1, 0);
    add(0, 0, 0, 0, 1, 1, 0,  2, 0, 0, 0);   // stop discards due tick
    // stop / resume from 5
    add(0, 1, 5, 0, 0, 0, 0,  5, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0,  5, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  4, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  3, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,  3, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  3, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0,  3, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  2, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1);
    // simultaneous events
    add(0, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0);   // load 0 + start -> IDLE
    add(0, 1, 4, 1, 0, 0, 0,  4, 1, 0, 0);   // load 4 + start -> RUN
    add(0, 0, 0, 0, 0, 0, 0,  3, 1, 0, 0);
    add(0, 1, 7, 0, 0, 0, 0,  7, 1, 0, 0);   // load in RUN, no tick
    add(0, 0, 0, 0, 0, 0, 0,  6, 1, 0, 0);
    // reset mid-run at count 6
    add(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0);   // start without load ignored
    add(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    // PRESCALE=3 one-shot from 2
    add(0, 1, 2, 0, 0, 0, 1,  2, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 1,  2, 1, 0, 0);   // edge N
    add(0, 0, 0, 0, 0, 0, 1,  2, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  2, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0);   // N+3
    add(0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 1);   // N+6
    add(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].sp, vecs[i].md);
      e.idx = i;
      e.p3  = vecs[i].p3;
      e.exp = {vecs[i].ec, vecs[i].er, vecs[i].et, vecs[i].ed};
      sbq.push_back(e);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      act = e.p3 ? {c3, r3, t3, d3} : {c1, r1, t1, d1};
      check($sformatf("vec%0d{count,run,tc,done}", e.idx), 32'(act), 32'(e.exp));
    end

    // Free-running auto-reload from 3 on both instances for 40 cycles.
    drive(1, 0, 0, 0, 0, 1);
    drive(0, 1, 3, 0, 0, 1);
    drive(0, 0, 0, 1, 0, 1);
    @(posedge clk);
    drive(0, 0, 0, 0, 0, 1);
    first_tc3 = -1; n_tc1 = 0; n_tc3 = 0; zero_seen = 0;
    // k counts edges after the start edge; the start edge itself is k=0
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (t1) n_tc1++;
      if (t3) begin
        n_tc3++;
        if (first_tc3 < 0) first_tc3 = k;
      end
      if (c1 == 4'd0 || c3 == 4'd0) zero_seen++;
    end
    check("reload_first_tc_p3", 32'(first_tc3), 32'd9);
    check("reload_tc_count_p3", 32'(n_tc3), 32'd4);
    check("reload_tc_count_p1", 32'(n_tc1), 32'd13);
    check("reload_count_zero_seen", 32'(zero_seen), 32'd0);
    check("reload_done_low", 32'({d1, d3}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
